// File: rtl/noc_pkg.sv
// noc_pkg: shared constants, packet/source types and the round-robin pick
// helper for the NoC merge arbiter.
//   NOC_WIDTH  packet width (flag, destination router, payload)
//   NOC_NUM_IN number of merged input channels
//   noc_pkt_t  packet layout: payload[10:4], dest[3:1], flag[0]
//   noc_src_t  2-bit input index carried alongside the output packet
package noc_pkg;

  localparam int unsigned NOC_WIDTH  = 11;
  localparam int unsigned NOC_NUM_IN = 3;
  localparam int unsigned NOC_SRC_W  = 2;
  localparam int unsigned NOC_CNT_W  = 16;

  typedef logic [NOC_SRC_W-1:0] noc_src_t;

  typedef struct packed {
    logic [6:0] payload;
    logic [2:0] dest;
    logic       flag;
  } noc_pkt_t;

  // First requester found searching upward from last+1, wrapping modulo NOC_NUM_IN.
  function automatic noc_src_t rr_pick(input logic [NOC_NUM_IN-1:0] req,
                                       input noc_src_t              last);
    noc_src_t    pick;
    logic        found;
    int unsigned idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= NOC_NUM_IN; k++) begin
      idx = (32'(last) + k) % NOC_NUM_IN;
      if (!found && req[idx[1:0]]) begin
        pick  = noc_src_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// noc_fifo: synchronous FIFO buffering one merge-arbiter input.
//   clk, reset     clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_push_data  write strobe and data (ignored when full)
//   i_pop          read strobe (ignored when empty)
//   o_head_c       combinational view of the oldest entry
//   o_count        registered occupancy, $clog2(DEPTH)+1 bits
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module noc_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_head_c,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  // Local guards keep the count consistent even if a caller misbehaves.
  assign w_push = i_push && (r_count < CNT_W'(DEPTH));
  assign w_pop  = i_pop && (r_count != '0);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head_c = r_mem[r_rd_ptr];
  assign o_count  = r_count;

endmodule

// File: rtl/noc_merge_arbiter.sv
// noc_merge_arbiter: merges three routing-logic channels into one registered
// output stream using per-input FIFOs and round-robin selection.
//   clk, reset   clock, synchronous active-high reset
//   in_valid/in_data/in_ready  per-input push interface (ready = FIFO not full)
//   out_valid/out_data/out_ready  registered output with downstream accept
//   out_src      index of the input that supplied out_data
//   grant_cnt    (only with NOC_ARB_GRANT_CNT_EN) saturating per-input load count
module noc_merge_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned WIDTH = NOC_WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NOC_NUM_IN-1:0]                in_valid,
  input  logic [NOC_NUM_IN-1:0][WIDTH-1:0]     in_data,
  output logic [NOC_NUM_IN-1:0]                in_ready,
  output logic                                 out_valid,
  output logic [WIDTH-1:0]                     out_data,
  input  logic                                 out_ready,
  output noc_src_t                             out_src
`ifdef NOC_ARB_GRANT_CNT_EN
  ,
  output logic [NOC_NUM_IN-1:0][NOC_CNT_W-1:0] grant_cnt
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [NOC_NUM_IN-1:0][WIDTH-1:0] w_head;
  logic [NOC_NUM_IN-1:0][CNT_W-1:0] w_count;
  logic [NOC_NUM_IN-1:0]            w_nonempty;
  logic [NOC_NUM_IN-1:0]            w_push;
  logic [NOC_NUM_IN-1:0]            w_pop;
  logic                             w_load;
  noc_src_t                         w_winner;

  logic                             r_out_valid;
  logic [WIDTH-1:0]                 r_out_data;
  noc_src_t                         r_out_src;
  noc_src_t                         r_last_grant;

  // Per-input buffers; ready is forced low while reset is held.
  for (genvar i = 0; i < NOC_NUM_IN; i++) begin : g_in
    assign in_ready[i]   = !reset && (w_count[i] < CNT_W'(DEPTH));
    assign w_push[i]     = in_valid[i] && in_ready[i];
    assign w_nonempty[i] = (w_count[i] != '0);
    assign w_pop[i]      = w_load && (w_winner == noc_src_t'(i));

    noc_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_push[i]),
      .i_push_data (in_data[i]),
      .i_pop       (w_pop[i]),
      .o_head_c    (w_head[i]),
      .o_count     (w_count[i])
    );
  end

  // Load when the output slot is free or draining; only registered FIFO state
  // feeds this, so a same-edge push cannot bypass to the output.
  assign w_winner = rr_pick(w_nonempty, r_last_grant);
  assign w_load   = (!r_out_valid || out_ready) && (|w_nonempty);

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_src    <= '0;
      r_last_grant <= noc_src_t'(NOC_NUM_IN - 1);
    end else if (w_load) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_head[w_winner];
      r_out_src    <= w_winner;
      r_last_grant <= w_winner;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;

`ifdef NOC_ARB_GRANT_CNT_EN
  logic [NOC_NUM_IN-1:0][NOC_CNT_W-1:0] r_grant_cnt;

  // Saturating per-input load counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_cnt <= '0;
    end else if (w_load && (r_grant_cnt[w_winner] != '1)) begin
      r_grant_cnt[w_winner] <= r_grant_cnt[w_winner] + NOC_CNT_W'(1);
    end
  end

  assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: doc/noc_merge_arbiter.md
NOC_MERGE_ARBITER -- requirements
Module: noc_merge_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 11, meaning packet width: bit0 flag, [3:1] destination router, [10:4] payload.
REQ-002 The block SHALL have parameter DEPTH, default 2, meaning entries per input FIFO; the value SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, listed first, as these two ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
REQ-004 The block SHALL have the following remaining ports:
- in_valid  input  3  per-input packet valid, one per routing-logic channel 1..3
- in_data  input  3xWIDTH  per-input packet
- in_ready  output  3  per-input FIFO not full
- out_valid  output  1  registered packet valid, towards the routing-logic arbiter input
- out_data  output  WIDTH  registered packet
- out_ready  input  1  downstream accept
- out_src  output  2  index (0..2) of the input that supplied out_data

Function
REQ-005 Input i SHALL push in_data[i] into FIFO i on any rising clk edge where in_valid[i] and in_ready[i] are both 1.
REQ-006 in_ready[i] SHALL equal "FIFO i count < DEPTH"; a full FIFO SHALL never accept a push.
REQ-007 A FIFO SHALL support a push and a pop in the same cycle, leaving its count unchanged.
REQ-008 The output register SHALL load when it is empty or being drained (out_valid and out_ready) and at least one FIFO is non-empty.
REQ-009 The winner SHALL be chosen round-robin among non-empty FIFOs: search starts at (last_grant+1) mod 3; last_grant resets to 2, so input 0 has first priority.
REQ-010 On load, the winner's head SHALL be popped and presented on out_data/out_src, with out_valid=1 from the next cycle.
REQ-011 last_grant SHALL update only on a load.
REQ-012 out_valid, out_data and out_src SHALL stay stable while out_valid=1 and out_ready=0.
REQ-013 Latency SHALL be 1 cycle: a packet pushed at edge N into an idle block SHALL appear with out_valid=1 after edge N+1. A packet pushed into an empty FIFO SHALL NOT bypass to the output in the same edge.
REQ-014 Sustained throughput SHALL be one packet per cycle when out_ready is held at 1.
REQ-015 Packets SHALL leave in per-input FIFO order; no packet SHALL be dropped, duplicated or modified.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH. Count width SHALL be $clog2(DEPTH)+1 bits.

Reset
REQ-017 While reset=1 at a rising edge, all FIFOs SHALL empty, last_grant SHALL become 2, out_valid SHALL become 0, out_data SHALL become 0 and out_src SHALL become 0.
REQ-018 While reset=1, in_ready SHALL be driven 0; it SHALL return to 1 in the first cycle after reset deasserts.
REQ-019 A reset asserted mid-transfer SHALL discard buffered and held packets without emitting them.

Configuration
REQ-020 With NOC_ARB_GRANT_CNT_EN defined, the block SHALL add output grant_cnt (3x16): per-input count of loads, saturating at 16'hFFFF and cleared by reset.
REQ-021 Without NOC_ARB_GRANT_CNT_EN, the grant_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-022 Package noc_pkg SHALL hold:
- NOC_WIDTH = 11
- NOC_NUM_IN = 3
- typedef noc_pkt_t: flag[0], dest[3:1], payload[10:4]
- typedef noc_src_t (2 bits)
REQ-023 The per-input buffer SHALL be sub-module noc_fifo (parameters WIDTH, DEPTH; synchronous, active-high reset), instantiated three times.

Verification
REQ-024 Single packet: reset, then 11'h2A6 on input 1 with out_ready=1 -> out_data=11'h2A6, out_src=1 exactly one cycle after the push; in_ready stays 111.
REQ-025 Contention: all three inputs push one packet in the same cycle (11'h010, 11'h022, 11'h034), out_ready=1 -> outputs appear in order src 0,1,2 on three consecutive cycles.
REQ-026 Backpressure: out_ready=0, input 0 pushes 3 packets with DEPTH=2 -> output holds the first packet, the FIFO holds 2, in_ready[0]=0; after out_ready=1, all 3 packets appear in order with no loss.
REQ-027 Fairness: all inputs continuously valid, out_ready=1 for 30 cycles -> out_src sequence is 0,1,2 repeating and each input is granted 10 times.
REQ-028 Mid-operation reset: FIFOs partly full and out_valid=1, reset pulsed for 1 cycle -> out_valid=0 the next cycle, no stale packet is ever emitted, and the next grant goes to input 0.
REQ-029 With NOC_ARB_GRANT_CNT_EN defined: preload grant_cnt[2]=16'hFFFE, then grant input 2 three times -> grant_cnt[2]=16'hFFFF and holds.
